// File: rtl/sram_port_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared definitions for the port-0 request controller of the 1RW+1R SRAM
// macros. It provides:
//   - default geometry (address/data width, byte lanes, response depth),
//   - the drive levels port 0 sits at when no access is issued,
//   - the response record carried through the response FIFO,
//   - a range check that maps a byte address onto the macro's word space.
// -----------------------------------------------------------------------------
package sram_ctrl_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_WMASKS = DEF_DATA_WIDTH / 8;
    localparam int DEF_RSP_DEPTH  = 4;

    // Port-0 drive levels for an idle cycle (chip select and write enable are active low)
    localparam logic SRAM_CSB_IDLE = 1'b1;
    localparam logic SRAM_WEB_IDLE = 1'b1;

    // One read response: data word plus out-of-range flag
    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] rdata;
        logic                      err;
    } rsp_t;

    // A byte address hits the macro only if every bit above the word index is zero
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input int unsigned addr_width);
        logic [31:0] upper;
        upper = addr >> (addr_width + 32'd2);
        return (upper == 32'd0);
    endfunction

endpackage

// File: rtl/sram_port_ctrl_if.sv
// -----------------------------------------------------------------------------
// sram_port_ctrl_if
// Request/response channel between a core/LSU and sram_port_ctrl.
//   req_valid/req_ready : request handshake (accepted when both high at posedge)
//   req_we              : 1 = write, 0 = read
//   req_addr            : byte address
//   req_wdata/req_wstrb : write data and byte enables
//   rsp_valid/rsp_ready : read-response handshake
//   rsp_rdata/rsp_err   : read data (0 on error) and out-of-range flag
// modport master : requester side (core/LSU, testbench)
// modport slave  : controller side
// -----------------------------------------------------------------------------
interface sram_port_ctrl_if
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_WMASKS = DEF_NUM_WMASKS
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [31:0]           req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [NUM_WMASKS-1:0] req_wstrb;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/sram_rsp_fifo.sv
// -----------------------------------------------------------------------------
// sram_rsp_fifo
// Synchronous FIFO holding read responses until the requester takes them.
//   clk, rst_n  : clock, asynchronous active-low reset (clears storage too,
//                 so the head reads as all-zero after reset)
//   i_push      : write i_push_data (ignored when full)
//   i_pop       : drop the head entry (ignored when empty)
//   o_head      : oldest entry
//   o_full      : DEPTH entries stored
//   o_empty     : no entry stored
// DEPTH must be a power of two, at least 2. Pointers carry one extra wrap bit
// so full and empty are told apart without a separate count.
// -----------------------------------------------------------------------------
module sram_rsp_fifo
    import sram_ctrl_pkg::*;
#(
    parameter int  DEPTH = DEF_RSP_DEPTH,
    parameter type T     = rsp_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_push,
    input  T     i_push_data,
    input  logic i_pop,
    output T     o_head,
    output logic o_full,
    output logic o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam T   ENTRY_ZERO = T'({$bits(T){1'b0}});

    T              r_mem [DEPTH];
    logic [PW:0]   r_wr_ptr;
    logic [PW:0]   r_rd_ptr;
    logic          w_push;
    logic          w_pop;

    // Full/empty flags and qualified push/pop strobes
    always_comb begin
        o_empty = (r_wr_ptr == r_rd_ptr);
        o_full  = (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]) &&
                  (r_wr_ptr[PW] != r_rd_ptr[PW]);
        w_push  = i_push && !o_full;
        w_pop   = i_pop && !o_empty;
        o_head  = r_mem[r_rd_ptr[PW-1:0]];
    end

    // Storage write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= ENTRY_ZERO;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr[PW-1:0]] <= i_push_data;
        end else begin
            r_mem[r_wr_ptr[PW-1:0]] <= r_mem[r_wr_ptr[PW-1:0]];
        end
    end

    // Write and read pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {(PW+1){1'b0}};
            r_rd_ptr <= {(PW+1){1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + {{PW{1'b0}}, 1'b1};
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{PW{1'b0}}, 1'b1};
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
        end
    end

endmodule

// File: rtl/sram_port_ctrl.sv
// -----------------------------------------------------------------------------
// sram_port_ctrl
// Port-0 request controller for a 1RW+1R OpenRAM macro. Turns a byte-addressed
// valid/ready request stream into registered csb0/web0/wmask0/addr0/din0
// drives, captures dout0 in its valid window and returns read data in order.
//   clk, rst_n      : clock (also the macro's clk0), async active-low reset
//   bus (slave)     : request/response channel (see sram_port_ctrl_if)
//   err_sticky      : set by any accepted out-of-range request, reset-only clear
//   sram_csb0/web0  : macro chip select / write enable (active low)
//   sram_wmask0     : macro byte write mask
//   sram_addr0/din0 : macro word address / write data
//   sram_dout0      : macro read data
// Pipeline: stage A holds the drives for the access the macro samples at the
// next edge; stage B tags the read the macro is executing; its data is pushed
// into the response FIFO at the edge that ends stage B. A credit counter caps
// (FIFO entries + reads in flight) at RSP_DEPTH so a push never meets a full
// FIFO.
// -----------------------------------------------------------------------------
module sram_port_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_WMASKS = DEF_NUM_WMASKS,
    parameter int RSP_DEPTH  = DEF_RSP_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sram_port_ctrl_if.slave       bus,
    output logic                  err_sticky,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic                  err;
    } rsp_entry_t;

    localparam int            CW         = $clog2(RSP_DEPTH) + 1;
    localparam logic [CW-1:0] CREDIT_MAX = CW'(RSP_DEPTH);
    localparam logic [CW-1:0] CREDIT_ONE = {{(CW-1){1'b0}}, 1'b1};

    // Stage A: port-0 drive registers
    logic                  r_csb0;
    logic                  r_web0;
    logic [NUM_WMASKS-1:0] r_wmask0;
    logic [ADDR_WIDTH-1:0] r_addr0;
    logic [DATA_WIDTH-1:0] r_din0;
    logic                  r_a_rd_vld;
    logic                  r_a_rd_err;
    // Stage B: read the macro is executing
    logic                  r_b_rd_vld;
    logic                  r_b_rd_err;
    // Credits and error flag
    logic [CW-1:0]         r_out_cnt;
    logic                  r_err_sticky;

    logic                  w_req_ready;
    logic                  w_req_fire;
    logic                  w_rd_fire;
    logic                  w_in_range;
    logic [ADDR_WIDTH-1:0] w_word_idx;
    logic                  w_rsp_fire;
    logic                  w_push;
    rsp_entry_t            w_push_data;
    rsp_entry_t            w_head;
    logic                  w_full;
    logic                  w_empty;

    // Request decode, handshakes and the response entry built from stage B
    always_comb begin
        w_req_ready = (r_out_cnt < CREDIT_MAX);
        w_req_fire  = bus.req_valid && w_req_ready;
        w_rd_fire   = w_req_fire && !bus.req_we;
        w_in_range  = addr_in_range(bus.req_addr, ADDR_WIDTH);
        w_word_idx  = bus.req_addr[ADDR_WIDTH+1:2];
        w_rsp_fire  = bus.rsp_ready && !w_empty;
        // w_full never blocks a push while credits hold; it is a safety net
        w_push      = r_b_rd_vld && !w_full;
        w_push_data.err = r_b_rd_err;
        if (r_b_rd_err) begin
            w_push_data.rdata = {DATA_WIDTH{1'b0}};
        end else begin
            w_push_data.rdata = sram_dout0;
        end
    end

    // Stage A: drives for the access sampled by the macro at the next edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_csb0   <= SRAM_CSB_IDLE;
            r_web0   <= SRAM_WEB_IDLE;
            r_wmask0 <= {NUM_WMASKS{1'b0}};
            r_addr0  <= {ADDR_WIDTH{1'b0}};
            r_din0   <= {DATA_WIDTH{1'b0}};
        end else if (w_req_fire) begin
            // Out-of-range requests keep the macro deselected
            r_csb0   <= ~w_in_range;
            r_web0   <= ~bus.req_we;
            r_wmask0 <= bus.req_we ? bus.req_wstrb : {NUM_WMASKS{1'b0}};
            r_addr0  <= w_word_idx;
            r_din0   <= bus.req_wdata;
        end else begin
            r_csb0   <= SRAM_CSB_IDLE;
            r_web0   <= SRAM_WEB_IDLE;
            r_wmask0 <= {NUM_WMASKS{1'b0}};
            r_addr0  <= r_addr0;
            r_din0   <= r_din0;
        end
    end

    // Read tags for stage A and stage B
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_rd_vld <= 1'b0;
            r_a_rd_err <= 1'b0;
            r_b_rd_vld <= 1'b0;
            r_b_rd_err <= 1'b0;
        end else begin
            r_a_rd_vld <= w_rd_fire;
            r_a_rd_err <= w_rd_fire && !w_in_range;
            r_b_rd_vld <= r_a_rd_vld;
            r_b_rd_err <= r_a_rd_err;
        end
    end

    // Credit counter: reads issued but not yet handed back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_cnt <= {CW{1'b0}};
        end else begin
            case ({w_rd_fire, w_rsp_fire})
                2'b10:   r_out_cnt <= r_out_cnt + CREDIT_ONE;
                2'b01:   r_out_cnt <= r_out_cnt - CREDIT_ONE;
                default: r_out_cnt <= r_out_cnt;
            endcase
        end
    end

    // Sticky out-of-range flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_sticky <= 1'b0;
        end else if (w_req_fire && !w_in_range) begin
            r_err_sticky <= 1'b1;
        end else begin
            r_err_sticky <= r_err_sticky;
        end
    end

    sram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .T     (rsp_entry_t)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_rsp_fire),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = !w_empty;
    assign bus.rsp_rdata = w_head.rdata;
    assign bus.rsp_err   = w_head.err;
    assign err_sticky    = r_err_sticky;
    assign sram_csb0     = r_csb0;
    assign sram_web0     = r_web0;
    assign sram_wmask0   = r_wmask0;
    assign sram_addr0    = r_addr0;
    assign sram_din0     = r_din0;

endmodule

// File: tb/tb_sram_port_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_port_ctrl
// Self-checking bench for sram_port_ctrl. A behavioural macro model drives
// dout0 only inside its valid window (random data elsewhere). A reference
// model tracks memory contents, expected responses (in order, with the cycle
// of acceptance), outstanding reads and the sticky error flag.
// -----------------------------------------------------------------------------
module tb_sram_port_ctrl;
    import sram_ctrl_pkg::*;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int NM    = 4;
    localparam int DEPTH = 4;
    localparam int WORDS = 1 << AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_port_ctrl_if #(.DATA_WIDTH(DW), .NUM_WMASKS(NM)) bus ();

    logic          err_sticky;
    logic          sram_csb0;
    logic          sram_web0;
    logic [NM-1:0] sram_wmask0;
    logic [AW-1:0] sram_addr0;
    logic [DW-1:0] sram_din0;
    logic [DW-1:0] sram_dout0;

    sram_port_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_WMASKS (NM),
        .RSP_DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .err_sticky  (err_sticky),
        .sram_csb0   (sram_csb0),
        .sram_web0   (sram_web0),
        .sram_wmask0 (sram_wmask0),
        .sram_addr0  (sram_addr0),
        .sram_din0   (sram_din0),
        .sram_dout0  (sram_dout0)
    );

    function automatic logic [31:0] init_word(input int i);
        return (i * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    // ---------------- macro model ----------------
    logic [31:0] sram_mem [WORDS];
    logic        mac_init = 1'b0;
    logic        rd_pend  = 1'b0;
    logic [31:0] rd_word;

    always @(clk) begin
        if (clk) begin
            if (!mac_init) begin
                for (int i = 0; i < WORDS; i++) sram_mem[i] <= init_word(i);
                mac_init <= 1'b1;
                rd_pend  <= 1'b0;
            end else if (!sram_csb0 && !sram_web0) begin
                for (int b = 0; b < NM; b++)
                    if (sram_wmask0[b]) sram_mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
                rd_pend <= 1'b0;
            end else if (!sram_csb0) begin
                rd_word <= sram_mem[sram_addr0];
                rd_pend <= 1'b1;
            end else begin
                rd_pend <= 1'b0;
            end
            sram_dout0 <= $urandom;
        end else begin
            if (rd_pend) sram_dout0 <= rd_word;
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] d;
        logic        e;
        int          cyc;
    } exp_t;

    logic [31:0]   ref_mem [WORDS];
    exp_t          exp_q [$];
    int            outstanding;
    logic          ref_sticky;
    logic          exp_csb, exp_web;
    logic [NM-1:0] exp_wmask;
    logic          chk_addr, chk_din;
    logic [AW-1:0] exp_addr;
    logic [31:0]   exp_din;
    int            cur;
    int            errors = 0;
    int            checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        outstanding = 0;
        ref_sticky  = 1'b0;
        exp_csb     = 1'b1;
        exp_web     = 1'b1;
        exp_wmask   = '0;
        chk_addr    = 1'b0;
        chk_din     = 1'b0;
    endtask

    // One clock: drive inputs, check at negedge, update model, advance to posedge+1
    task automatic cycle(input logic v, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] st,
                         input logic rr, output logic acc);
        logic        hs, inr, exp_valid;
        logic [AW-1:0] idx;
        exp_t        e;
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        bus.req_wstrb = st;
        bus.rsp_ready = rr;
        cur++;
        @(negedge clk);
        check("req_ready", bus.req_ready, outstanding < DEPTH);
        exp_valid = (exp_q.size() > 0) && (cur >= exp_q[0].cyc + 3);
        check("rsp_valid", bus.rsp_valid, exp_valid);
        check("err_sticky", err_sticky, ref_sticky);
        check("csb0", sram_csb0, exp_csb);
        check("web0", sram_web0, exp_web);
        check("wmask0", sram_wmask0, exp_wmask);
        if (chk_addr) check("addr0", sram_addr0, exp_addr);
        if (chk_din) check("din0", sram_din0, exp_din);
        acc = v && bus.req_ready;
        hs  = bus.rsp_valid && rr;
        if (hs) begin
            check("rsp_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rsp_rdata", bus.rsp_rdata, e.d);
                check("rsp_err", bus.rsp_err, e.e);
            end
            outstanding--;
        end
        inr = (a[31:AW+2] == '0);
        idx = a[AW+1:2];
        exp_csb   = !(acc && inr);
        exp_web   = acc ? !we : 1'b1;
        exp_wmask = (acc && we) ? st : '0;
        chk_addr  = acc && inr;
        chk_din   = acc && inr && we;
        exp_addr  = idx;
        exp_din   = wd;
        if (acc) begin
            if (!inr) ref_sticky = 1'b1;
            if (we) begin
                if (inr)
                    for (int b = 0; b < NM; b++)
                        if (st[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
            end else begin
                e.d   = inr ? ref_mem[idx] : 32'h0;
                e.e   = !inr;
                e.cyc = cur;
                exp_q.push_back(e);
                outstanding++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        logic acc;
        for (int t = 0; t < 30 && exp_q.size() > 0; t++) cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, acc);
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, acc);
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        int          nacc, k, idx;
        logic        v, we, rr;
        logic [31:0] a, wd;
        logic [3:0]  st;

        for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
        model_reset();
        cur = 0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 32'h0;
        bus.req_wdata = 32'h0; bus.req_wstrb = 4'h0; bus.rsp_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", bus.req_ready, 1'b1);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        check("rst_rsp_err", bus.rsp_err, 1'b0);
        check("rst_err_sticky", err_sticky, 1'b0);
        check("rst_csb0", sram_csb0, 1'b1);
        check("rst_web0", sram_web0, 1'b1);
        check("rst_wmask0", sram_wmask0, 4'h0);
        check("rst_addr0", sram_addr0, 8'h0);
        check("rst_din0", sram_din0, 32'h0);
        rst_n = 1'b1;

        // Write then read-after-write next cycle
        cycle(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, acc);
        cycle(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, acc);
        drain();

        // Byte-masked overwrite
        cycle(1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, 1'b1, acc);
        cycle(1'b1, 1'b1, 32'h20, 32'h00000012, 4'h1, 1'b1, acc);
        cycle(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, acc);
        drain();
        check("masked_ref", ref_mem[8], 32'hFFFFFF12);

        // Strobe 0000 write leaves the word untouched
        cycle(1'b1, 1'b1, 32'h20, 32'h12345678, 4'h0, 1'b1, acc);
        cycle(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, acc);
        drain();

        // Backpressure: 6 reads with rsp_ready low, only 4 accepted
        nacc = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0, 32'h40 + 32'(4 * nacc), 32'h0, 4'h0, 1'b0, acc);
            if (acc) nacc++;
        end
        check("bp_accepts", nacc, 4);
        k = nacc;
        for (int t = 0; t < 40 && k < 6; t++) begin
            cycle(1'b1, 1'b0, 32'h40 + 32'(4 * k), 32'h0, 4'h0, 1'b1, acc);
            if (acc) k++;
        end
        check("bp_remaining", k, 6);
        drain();

        // Out-of-range read between two valid reads
        cycle(1'b1, 1'b0, 32'h44, 32'h0, 4'h0, 1'b1, acc);
        cycle(1'b1, 1'b0, 32'h400, 32'h0, 4'h0, 1'b1, acc);
        cycle(1'b1, 1'b0, 32'h48, 32'h0, 4'h0, 1'b1, acc);
        drain();
        check("oor_sticky", err_sticky, 1'b1);

        // Streaming reads: every request accepted
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, 32'(4 * i), 32'h0, 4'h0, 1'b1, acc);
            check("stream_acc", acc, 1'b1);
        end
        drain();

        // Randomized traffic over a small address window
        for (int i = 0; i < 400; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            we  = ($urandom_range(0, 2) == 0);
            idx = $urandom_range(0, 15);
            a   = 32'(idx * 4) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) a = a | (32'h1 << $urandom_range(10, 31));
            wd  = $urandom;
            st  = 4'($urandom_range(0, 15));
            rr  = ($urandom_range(0, 3) != 0);
            cycle(v, we, a, wd, st, rr, acc);
        end
        drain();

        // Reset with two reads in flight
        cycle(1'b1, 1'b0, 32'h14, 32'h0, 4'h0, 1'b1, acc);
        cycle(1'b1, 1'b0, 32'h18, 32'h0, 4'h0, 1'b1, acc);
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_csb0", sram_csb0, 1'b1);
        check("midrst_rsp_valid", bus.rsp_valid, 1'b0);
        check("midrst_req_ready", bus.req_ready, 1'b1);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, acc);
        check("post_rst_req_ready", bus.req_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_port_ctrl.md
# sram_port_ctrl

Request-side controller for the 1RW+1R OpenRAM SRAM macros (instruction and data memories). It turns a valid/ready byte-addressed request stream from the core/LSU into correctly timed `csb0/web0/wmask0/addr0/din0` drives on port 0. It captures `dout0` in the single window where the macro holds it valid and returns read data in order through a backpressured response channel. Port 1 (read-only) is not driven by this block.

## Interface
- `ADDR_WIDTH`, 8, SRAM word-address width.
- `DATA_WIDTH`, 32, data width.
- `NUM_WMASKS`, 4, byte lanes (`DATA_WIDTH/8`).
- `RSP_DEPTH`, 4, response FIFO depth = max outstanding reads (power of 2, ≥2).

Ports:
- `clk  in  1`  single clock; also drives the macro's `clk0`.
- `rst_n  in  1`  asynchronous, active-low reset.
- `req_valid  in  1`  request present.
- `req_ready  out  1`  request accepted when `req_valid && req_ready` at posedge.
- `req_we  in  1`  1 = write, 0 = read.
- `req_addr  in  32`  byte address; word index = `req_addr[ADDR_WIDTH+1:2]`, bits [1:0] ignored.
- `req_wdata  in  DATA_WIDTH`  write data.
- `req_wstrb  in  NUM_WMASKS`  byte enables.
- `rsp_valid  out  1`  read response present.
- `rsp_ready  in  1`  response consumed when `rsp_valid && rsp_ready`.
- `rsp_rdata  out  DATA_WIDTH`  read data; 0 when `rsp_err`.
- `rsp_err  out  1`  read address out of range.
- `err_sticky  out  1`  set by any out-of-range request; cleared only by reset.
- `sram_csb0  out  1`  to macro `csb0`, active low.
- `sram_web0  out  1`  to macro `web0`, active low.
- `sram_wmask0  out  NUM_WMASKS`  to macro `wmask0`.
- `sram_addr0  out  ADDR_WIDTH`  to macro `addr0`.
- `sram_din0  out  DATA_WIDTH`  to macro `din0`.
- `sram_dout0  in  DATA_WIDTH`  from macro `dout0`.

## Operation
- Out of range: `req_addr[31:ADDR_WIDTH+2] != 0`. Such a request drives no SRAM access (`csb0` stays 1) and sets `err_sticky`. A read still returns an in-order response with `rsp_err=1` and `rdata=0`. A write is dropped.
- Stage A (drive regs): registered from the accepted request. `csb0=0` only for in-range requests, `web0=~req_we`, `wmask0=req_wstrb` for writes and 0 for reads. With no request accepted: `csb0=1`, `web0=1`, `wmask0=0`; addr/din hold.
- Stage B: a read-tag register (valid, err) tracks the read the macro is currently executing.
- Capture: at the posedge ending stage B, `sram_dout0` (or 0 if err) is pushed into the response FIFO (`RSP_DEPTH`).
- Credits: counter `out_cnt` (0..`RSP_DEPTH`). +1 on read accept, −1 on response handshake, unchanged when both occur. Writes take no credit.
- `req_ready = (out_cnt < RSP_DEPTH)`. This is combinational from registered state only; it does not depend on `req_valid`.
- Writes produce no response. Strobe `0000` write: `csb0=0`, no bytes change.

## Timing
- Reset values: `req_ready=1`, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, `err_sticky=0`, `sram_csb0=1`, `sram_web0=1`, `sram_wmask0=0`, `sram_addr0=0`, `sram_din0=0`. FIFO, stage B and `out_cnt` are cleared.
- Read accepted at edge N: macro samples at N+1, `dout0` is valid from negedge N+1 to N+2, and is captured at N+2. `rsp_valid=1` after N+2 (latency 2) if the FIFO was empty.
- Throughput: one request per cycle sustained while `rsp_ready=1`.
- Read-after-write to the same address in the next cycle returns the new data (macro writes at negedge N+1, before the read sample at N+2).
- FIFO full plus 2 in flight cannot occur: credits bound FIFO occupancy plus in-flight reads to `RSP_DEPTH`.
- Push and pop in the same cycle: occupancy is unchanged and data order is preserved.
- Reset asserted mid-operation: all in-flight reads are discarded and `csb0` goes to 1 immediately (asynchronously). No response appears after deassertion.

## Structure
- Package `sram_ctrl_pkg`: default widths, `RSP_DEPTH`, a response struct (`rdata`, `err`), and the SRAM idle-drive constants.
- Sub-module `sram_rsp_fifo`: synchronous FIFO (depth `RSP_DEPTH`, async active-low reset) with push/pop/full/empty.
- This block contains stage A/B, the credit counter and range check.

## Test plan
- Write 0xDEADBEEF strb 1111 to 0x10, then read 0x10 on the next cycle → `rsp_rdata=0xDEADBEEF`, `rsp_err=0`, 2 cycles after read accept.
- Write 0xFFFFFFFF to 0x20, then 0x00000012 strb 0001 to 0x20, then read → 0xFFFFFF12.
- `rsp_ready=0`, issue 6 back-to-back reads → exactly 4 accepted, `req_ready=0`. Release `rsp_ready` → 4 responses in address order, then the remaining 2 are accepted.
- Read 0x400 (out of range with `ADDR_WIDTH=8`) between two valid reads → 3 in-order responses, the middle one with `rsp_err=1` and `rdata=0`. `err_sticky=1`; `sram_csb0` stays 1 for that slot.
- Streaming reads of 16 words with `rsp_ready=1` → one response per cycle; `req_ready` never drops.
- Assert `rst_n=0` with 2 reads in flight → `sram_csb0=1` and `rsp_valid=0` immediately. No responses after release; `out_cnt=0` (`req_ready=1`).
